// File: rtl/pong_match_ctrl_if.sv
// pong_match_ctrl_if: match-controller bus between input/physics logic and render stage.
// master drives the event inputs; slave is the match controller.
interface pong_match_ctrl_if;
  localparam int unsigned SCORE_W = 10;

  logic               frame_tick;
  logic               start_btn;
  logic               ball_out_left;
  logic               ball_out_right;
  logic               pause_btn;
  logic               game_en;
  logic               ball_run;
  logic               ball_reset;
  logic               serve_dir;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               p1_win;
  logic               p2_win;

  modport master (
    output frame_tick, start_btn, ball_out_left, ball_out_right, pause_btn,
    input  game_en, ball_run, ball_reset, serve_dir, p1_score, p2_score, p1_win, p2_win
  );

  modport slave (
    input  frame_tick, start_btn, ball_out_left, ball_out_right, pause_btn,
    output game_en, ball_run, ball_reset, serve_dir, p1_score, p2_score, p1_win, p2_win
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer (IDLE/SERVE/PLAY/POINT/WIN) owning scores, win
// flags and the ball-physics gate. Optional pause support when PONG_PAUSE_EN is defined.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_FRAMES   = 300
) (
  input  logic             clk,
  input  logic             rst,
  pong_match_ctrl_if.slave bus
);
  localparam int unsigned SCORE_W = 10;
  localparam int unsigned CNT_W   = 10;
  localparam logic [SCORE_W-1:0] WIN_PTS    = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   WIN_LAST   = CNT_W'(WIN_FRAMES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_WIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic             start_prev;
  logic             serve_pending;  // new match: recentre one cycle after scores clear
  logic             point_p2;       // last point went to P2
  logic             start_edge;
  logic             win_hit;

  assign start_edge = bus.start_btn & ~start_prev;
  assign win_hit    = point_p2 ? (bus.p2_score == WIN_PTS) : (bus.p1_score == WIN_PTS);

`ifdef PONG_PAUSE_EN
  logic pause_prev;
  logic paused;
  logic paused_nxt;

  // Pause toggles only while the ball is being served or played
  always_comb begin
    paused_nxt = paused;
    if (bus.pause_btn && !pause_prev && (state == S_SERVE || state == S_PLAY))
      paused_nxt = ~paused;
  end

  // Pause flag; dropped in IDLE/WIN and when a point ends the match
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_prev <= 1'b0;
      paused     <= 1'b0;
    end else begin
      pause_prev <= bus.pause_btn;
      if (state == S_IDLE || state == S_WIN || (state == S_POINT && win_hit))
        paused <= 1'b0;
      else
        paused <= paused_nxt;
    end
  end
`else
  logic paused;
  logic paused_nxt;
  logic unused_pause_btn;

  assign paused           = 1'b0;
  assign paused_nxt       = 1'b0;
  assign unused_pause_btn = bus.pause_btn;
`endif

  // Match FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      frame_cnt      <= '0;
      start_prev     <= 1'b0;
      serve_pending  <= 1'b0;
      point_p2       <= 1'b0;
      bus.game_en    <= 1'b0;
      bus.ball_run   <= 1'b0;
      bus.ball_reset <= 1'b0;
      bus.serve_dir  <= 1'b0;
      bus.p1_score   <= '0;
      bus.p2_score   <= '0;
      bus.p1_win     <= 1'b0;
      bus.p2_win     <= 1'b0;
    end else begin
      start_prev     <= bus.start_btn;
      bus.ball_reset <= 1'b0;
      serve_pending  <= 1'b0;
      case (state)
        S_IDLE, S_WIN: begin
          if (start_edge) begin
            state         <= S_SERVE;
            frame_cnt     <= '0;
            serve_pending <= 1'b1;
            bus.p1_score  <= '0;
            bus.p2_score  <= '0;
            bus.p1_win    <= 1'b0;
            bus.p2_win    <= 1'b0;
            bus.serve_dir <= 1'b0;
            bus.game_en   <= 1'b1;
            bus.ball_run  <= 1'b0;
          end else if (state == S_WIN && bus.frame_tick) begin
            if (frame_cnt == WIN_LAST) begin
              state       <= S_IDLE;
              frame_cnt   <= '0;
              bus.game_en <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        S_SERVE: begin
          bus.ball_reset <= serve_pending;
          bus.ball_run   <= 1'b0;
          if (bus.frame_tick && !paused) begin
            if (frame_cnt == SERVE_LAST) begin
              state        <= S_PLAY;
              frame_cnt    <= '0;
              bus.ball_run <= ~paused_nxt;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        S_PLAY: begin
          bus.ball_run <= ~paused_nxt;
          if (!paused && bus.ball_out_left) begin
            bus.p2_score <= bus.p2_score + SCORE_W'(1);
            point_p2     <= 1'b1;
            state        <= S_POINT;
            frame_cnt    <= '0;
            bus.ball_run <= 1'b0;
          end else if (!paused && bus.ball_out_right) begin
            bus.p1_score <= bus.p1_score + SCORE_W'(1);
            point_p2     <= 1'b0;
            state        <= S_POINT;
            frame_cnt    <= '0;
            bus.ball_run <= 1'b0;
          end
        end
        S_POINT: begin
          bus.ball_run <= 1'b0;
          frame_cnt    <= '0;
          if (win_hit) begin
            state <= S_WIN;
            if (point_p2) bus.p2_win <= 1'b1;
            else          bus.p1_win <= 1'b1;
          end else begin
            state          <= S_SERVE;
            bus.serve_dir  <= ~point_p2;  // serve toward the player who conceded
            bus.ball_reset <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
